pmem_arbiter: RTL

Two-port arbiter that shares the single cacheline adaptor / physical-memory port between the instruction cache (read-only) and the data cache (read/write). It sits between the two cache controllers and the adaptor. It latches one whole-line transaction at a time, holds it stable downstream until the memory responds, and routes the response back to the owning cache. Simultaneous requests are resolved round-robin, so neither cache waits longer than one foreign transaction.

---
 rtl/pmem_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one cacheline adaptor port between the I-cache and
// the D-cache. It latches one whole-line transaction at a time, holds it
// stable until the adaptor responds, and routes the response back to the
// cache that owns the transaction. Ties are broken round-robin.
module pmem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    i_mem_read,
    input  logic [ADDR_W-1:0]       i_mem_address,
    output logic [LINE_W-1:0]       i_mem_rdata,
    output logic                    i_mem_resp,

    input  logic                    d_mem_read,
    input  logic                    d_mem_write,
    input  logic [ADDR_W-1:0]       d_mem_address,
    input  logic [LINE_W-1:0]       d_mem_wdata,
    input  logic [(LINE_W/8)-1:0]   d_mem_byte_enable,
    output logic [LINE_W-1:0]       d_mem_rdata,
    output logic                    d_mem_resp,

    output logic                    p_mem_read,
    output logic                    p_mem_write,
    output logic [ADDR_W-1:0]       p_mem_address,
    output logic [LINE_W-1:0]       p_mem_wdata,
    output logic [(LINE_W/8)-1:0]   p_mem_byte_enable,
    input  logic [LINE_W-1:0]       p_mem_rdata,
    input  logic                    p_mem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t state;
    logic   last_grant_d;   // 1 when the most recent completed transaction was D's
    logic   i_req;
    logic   d_req;
    logic   grant_i;

    // Request decode; on a tie the port that was not served last wins
    assign i_req   = i_mem_read;
    assign d_req   = d_mem_read | d_mem_write;
    assign grant_i = i_req & (~d_req | last_grant_d);

    // Responses are steered to the owner only; read data is shared by both caches
    assign i_mem_resp  = (state == SERVE_I) & p_mem_resp;
    assign d_mem_resp  = (state == SERVE_D) & p_mem_resp;
    assign i_mem_rdata = p_mem_rdata;
    assign d_mem_rdata = p_mem_rdata;

    // Arbitration FSM with latched downstream command
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            last_grant_d      <= 1'b1;
            p_mem_read        <= 1'b0;
            p_mem_write       <= 1'b0;
            p_mem_address     <= '0;
            p_mem_wdata       <= '0;
            p_mem_byte_enable <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        state         <= SERVE_I;
                        p_mem_address <= i_mem_address;
                        p_mem_read    <= 1'b1;
                        p_mem_write   <= 1'b0;
                    end else if (d_req) begin
                        // Write takes priority if D illegally asserts both
                        state             <= SERVE_D;
                        p_mem_address     <= d_mem_address;
                        p_mem_wdata       <= d_mem_wdata;
                        p_mem_byte_enable <= d_mem_byte_enable;
                        p_mem_read        <= ~d_mem_write;
                        p_mem_write       <= d_mem_write;
                    end
                end
                SERVE_I: begin
                    if (p_mem_resp) begin
                        state        <= IDLE;
                        last_grant_d <= 1'b0;
                        p_mem_read   <= 1'b0;
                        p_mem_write  <= 1'b0;
                    end
                end
                SERVE_D: begin
                    if (p_mem_resp) begin
                        state        <= IDLE;
                        last_grant_d <= 1'b1;
                        p_mem_read   <= 1'b0;
                        p_mem_write  <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    p_mem_read  <= 1'b0;
                    p_mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule
